// File: rtl/fb_pkg.sv
// Shared types and width helpers for the framebuffer write scheduler.
// Holds the FSM/turn enums and pixel/coordinate width functions.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_e;

    typedef enum logic {
        TURN_HOST,
        TURN_FILL
    } turn_e;

    function automatic int pixel_width(input int r, input int g, input int b);
        return r + g + b;
    endfunction

    function automatic int coord_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fb_write_scheduler_walker.sv
// Column-major rectangle walker: x outer, y inner, address stepped
// incrementally (+1 per row, column start + V on column wrap).
module fb_rect_walker
    import fb_pkg::*;
#(
    parameter int XW             = 9,
    parameter int YW             = 8,
    parameter int V_VISIBLE_AREA = 240,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [XW-1:0]         x0,
    input  logic [YW-1:0]         y0,
    input  logic [XW-1:0]         x_last,
    input  logic [YW-1:0]         y_last,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] V_STEP = ADDR_WIDTH'(V_VISIBLE_AREA);

    logic [XW-1:0]         x_q, x_d, xl_q, xl_d;
    logic [YW-1:0]         y_q, y_d, y0_q, y0_d, yl_q, yl_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, col_q, col_d;
    logic [ADDR_WIDTH-1:0] origin;

    assign origin = ADDR_WIDTH'(x0) * V_STEP + ADDR_WIDTH'(y0);
    assign addr   = addr_q;
    assign last   = (x_q == xl_q) && (y_q == yl_q);

    // Load a new origin or step one pixel down / to the next column
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        y0_d   = y0_q;
        xl_d   = xl_q;
        yl_d   = yl_q;
        addr_d = addr_q;
        col_d  = col_q;
        if (load) begin
            x_d    = x0;
            y_d    = y0;
            y0_d   = y0;
            xl_d   = x_last;
            yl_d   = y_last;
            addr_d = origin;
            col_d  = origin;
        end else if (advance) begin
            if (y_q == yl_q) begin
                x_d    = x_q + XW'(1);
                y_d    = y0_q;
                col_d  = col_q + V_STEP;
                addr_d = col_q + V_STEP;
            end else begin
                y_d    = y_q + YW'(1);
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Walker position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            y0_q   <= '0;
            xl_q   <= '0;
            yl_q   <= '0;
            addr_q <= '0;
            col_q  <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            y0_q   <= y0_d;
            xl_q   <= xl_d;
            yl_q   <= yl_d;
            addr_q <= addr_d;
            col_q  <= col_d;
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port owner: arbitrates host pixels vs. rectangle fill.
// Optional FB_WRITE_COUNT_EN adds a 32-bit write_count output.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int RED_WIDTH      = 4,
    parameter int GREEN_WIDTH    = 4,
    parameter int BLUE_WIDTH     = 4,
    parameter int H_VISIBLE_AREA = 320,
    parameter int V_VISIBLE_AREA = 240,
    parameter int ADDR_WIDTH     = 32,
    parameter int PIXEL_WIDTH    = pixel_width(RED_WIDTH, GREEN_WIDTH, BLUE_WIDTH),
    parameter int XW             = coord_width(H_VISIBLE_AREA),
    parameter int YW             = coord_width(V_VISIBLE_AREA)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [XW-1:0]          host_x,
    input  logic [YW-1:0]          host_y,
    input  logic [PIXEL_WIDTH-1:0] host_pixel,
    input  logic                   fill_start,
    input  logic [XW-1:0]          fill_x0,
    input  logic [YW-1:0]          fill_y0,
    input  logic [XW:0]            fill_w,
    input  logic [YW:0]            fill_h,
    input  logic [PIXEL_WIDTH-1:0] fill_color,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic                   err_oob,
    output logic                   write_enable,
    output logic [ADDR_WIDTH-1:0]  write_addr,
    output logic [PIXEL_WIDTH-1:0] pixel_in
`ifdef FB_WRITE_COUNT_EN
    ,
    output logic [31:0]            write_count
`endif
);

    localparam logic [XW+1:0] H_LIM = (XW+2)'(H_VISIBLE_AREA);
    localparam logic [YW+1:0] V_LIM = (YW+2)'(V_VISIBLE_AREA);

    state_e                 state_q, state_d;
    turn_e                  turn_q, turn_d;
    logic [PIXEL_WIDTH-1:0] color_q, color_d;
    logic                   we_q, we_d;
    logic                   err_q, err_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [PIXEL_WIDTH-1:0] pix_q, pix_d;

    logic [XW+1:0]          x_sum, x_end;
    logic [YW+1:0]          y_sum, y_end;
    logic [XW-1:0]          x_last;
    logic [YW-1:0]          y_last;
    logic                   fill_empty;
    logic                   host_oob, host_fire;
    logic [ADDR_WIDTH-1:0]  host_addr;
    logic                   fill_grant, walk_load, walk_last;
    logic [ADDR_WIDTH-1:0]  walk_addr;

    // Clip the requested rectangle to the visible framebuffer
    always_comb begin
        x_sum      = {2'b00, fill_x0} + {1'b0, fill_w};
        y_sum      = {2'b00, fill_y0} + {1'b0, fill_h};
        x_end      = (x_sum > H_LIM) ? H_LIM : x_sum;
        y_end      = (y_sum > V_LIM) ? V_LIM : y_sum;
        x_last     = XW'(x_end - (XW+2)'(1));
        y_last     = YW'(y_end - (YW+2)'(1));
        fill_empty = (fill_w == '0) || (fill_h == '0)
                  || ({2'b00, fill_x0} >= H_LIM)
                  || ({2'b00, fill_y0} >= V_LIM);
    end

    assign host_oob  = ({2'b00, host_x} >= H_LIM)
                    || ({2'b00, host_y} >= V_LIM);
    assign host_addr = ADDR_WIDTH'(host_x) * ADDR_WIDTH'(V_VISIBLE_AREA)
                     + ADDR_WIDTH'(host_y);
    assign host_fire = host_valid && host_ready;

    // Fill FSM, turn-bit arbitration and status outputs
    always_comb begin
        state_d    = state_q;
        turn_d     = turn_q;
        color_d    = color_q;
        host_ready = 1'b0;
        fill_busy  = 1'b0;
        fill_done  = 1'b0;
        fill_grant = 1'b0;
        walk_load  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                host_ready = 1'b1;
                if (fill_start) begin
                    walk_load = !fill_empty;
                    color_d   = fill_color;
                    turn_d    = TURN_HOST;
                    state_d   = fill_empty ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                fill_busy  = 1'b1;
                host_ready = (turn_q == TURN_HOST);
                // an unused host slot falls through to the fill
                fill_grant = !(host_valid && host_ready);
                turn_d     = (host_valid && host_ready) ? TURN_FILL : TURN_HOST;
                if (fill_grant && walk_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fill_done  = 1'b1;
                host_ready = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (reset) begin
            host_ready = 1'b0;
            fill_busy  = 1'b0;
            fill_done  = 1'b0;
        end
    end

    // Select the single write for next cycle's registered port
    always_comb begin
        we_d   = 1'b0;
        err_d  = 1'b0;
        addr_d = addr_q;
        pix_d  = pix_q;
        if (host_fire) begin
            if (host_oob) begin
                err_d = 1'b1;
            end else begin
                we_d   = 1'b1;
                addr_d = host_addr;
                pix_d  = host_pixel;
            end
        end else if (fill_grant) begin
            we_d   = 1'b1;
            addr_d = walk_addr;
            pix_d  = color_q;
        end
    end

    // State, turn and write-port registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            turn_q  <= TURN_HOST;
            color_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            color_q <= color_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
        end
    end

    assign write_enable = we_q;
    assign write_addr   = addr_q;
    assign pixel_in     = pix_q;
    assign err_oob      = err_q;

    fb_rect_walker #(
        .XW             (XW),
        .YW             (YW),
        .V_VISIBLE_AREA (V_VISIBLE_AREA),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_walker (
        .clk     (clk),
        .reset   (reset),
        .load    (walk_load),
        .advance (fill_grant),
        .x0      (fill_x0),
        .y0      (fill_y0),
        .x_last  (x_last),
        .y_last  (y_last),
        .addr    (walk_addr),
        .last    (walk_last)
    );

`ifdef FB_WRITE_COUNT_EN
    logic [31:0] wcnt_q, wcnt_d;

    // Count issued writes, wrapping at 2^32
    always_comb begin
        wcnt_d = wcnt_q + {31'b0, we_q};
    end

    // Write counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign write_count = wcnt_q;
`endif

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: host vector table plus
// hand-written fill, arbitration, clipping and reset sequences.
module tb_fb_write_scheduler;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int PW = 12;
    localparam int AW = 32;

    logic          clk;
    logic          reset;
    logic          host_valid;
    logic          host_ready;
    logic [XW-1:0] host_x;
    logic [YW-1:0] host_y;
    logic [PW-1:0] host_pixel;
    logic          fill_start;
    logic [XW-1:0] fill_x0;
    logic [YW-1:0] fill_y0;
    logic [XW:0]   fill_w;
    logic [YW:0]   fill_h;
    logic [PW-1:0] fill_color;
    logic          fill_busy;
    logic          fill_done;
    logic          err_oob;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [PW-1:0] pixel_in;
`ifdef FB_WRITE_COUNT_EN
    logic [31:0]   write_count;
`endif

    int tests = 0;
    int fails = 0;

    fb_write_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_x       (host_x),
        .host_y       (host_y),
        .host_pixel   (host_pixel),
        .fill_start   (fill_start),
        .fill_x0      (fill_x0),
        .fill_y0      (fill_y0),
        .fill_w       (fill_w),
        .fill_h       (fill_h),
        .fill_color   (fill_color),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .err_oob      (err_oob),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .pixel_in     (pixel_in)
`ifdef FB_WRITE_COUNT_EN
        ,
        .write_count  (write_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [PW-1:0] pix;
        logic          we;
        logic [AW-1:0] addr;
        logic          err;
    } hvec_t;

    hvec_t hv[6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input string nm, input int x0, input int y0,
                            input int w, input int h,
                            input logic [PW-1:0] col,
                            input bit hmode, input bit poke);
        int            ea[$];
        logic [PW-1:0] ep[$];
        int            xe, ye, n;
        xe = (x0 + w > 320) ? 320 : x0 + w;
        ye = (y0 + h > 240) ? 240 : y0 + h;
        for (int x = x0; x < xe; x++) begin
            for (int y = y0; y < ye; y++) begin
                if (hmode) begin
                    ea.push_back(1 * 240 + 1);
                    ep.push_back(12'h0F0);
                end
                ea.push_back(x * 240 + y);
                ep.push_back(col);
            end
        end
        n = ea.size();
        fill_x0    = XW'(x0);
        fill_y0    = YW'(y0);
        fill_w     = (XW+1)'(w);
        fill_h     = (YW+1)'(h);
        fill_color = col;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        if (n == 0) begin
            chk({nm, " empty done"}, fill_done, 1);
            chk({nm, " empty we"}, write_enable, 0);
            tick();
            chk({nm, " empty done end"}, fill_done, 0);
            chk({nm, " empty we end"}, write_enable, 0);
            return;
        end
        chk({nm, " busy"}, fill_busy, 1);
        chk({nm, " first we"}, write_enable, 0);
        if (hmode) begin
            host_valid = 1'b1;
            host_x     = 9'd1;
            host_y     = 8'd1;
            host_pixel = 12'h0F0;
        end
        if (poke) begin
            fill_start = 1'b1;
            fill_x0    = '0;
            fill_y0    = '0;
            fill_w     = 10'd1;
            fill_h     = 9'd1;
        end
        for (int k = 0; k < n; k++) begin
            if (hmode) begin
                chk($sformatf("%s ready %0d", nm, k), host_ready,
                    ((k % 2) == 0) ? 64'd1 : 64'd0);
            end
            tick();
            fill_start = 1'b0;
            chk($sformatf("%s we %0d", nm, k), write_enable, 1);
            chk($sformatf("%s addr %0d", nm, k), write_addr, ea[k]);
            chk($sformatf("%s pix %0d", nm, k), pixel_in, ep[k]);
            chk($sformatf("%s done %0d", nm, k), fill_done,
                (k == n - 1) ? 64'd1 : 64'd0);
        end
        host_valid = 1'b0;
        if (poke) begin
            fill_start = 1'b1;
        end
        tick();
        fill_start = 1'b0;
        chk({nm, " done end"}, fill_done, 0);
        chk({nm, " busy end"}, fill_busy, 0);
        chk({nm, " we end"}, write_enable, 0);
    endtask

    initial begin
        hv[0] = '{x: 9'd3,   y: 8'd5,   pix: 12'hABC, we: 1'b1, addr: 725,   err: 1'b0};
        hv[1] = '{x: 9'd320, y: 8'd0,   pix: 12'h555, we: 1'b0, addr: 0,     err: 1'b1};
        hv[2] = '{x: 9'd0,   y: 8'd0,   pix: 12'h123, we: 1'b1, addr: 0,     err: 1'b0};
        hv[3] = '{x: 9'd5,   y: 8'd240, pix: 12'h555, we: 1'b0, addr: 0,     err: 1'b1};
        hv[4] = '{x: 9'd319, y: 8'd239, pix: 12'hFFF, we: 1'b1, addr: 76799, err: 1'b0};
        hv[5] = '{x: 9'd100, y: 8'd100, pix: 12'hA5A, we: 1'b1, addr: 24100, err: 1'b0};

        reset      = 1'b1;
        host_valid = 1'b0;
        host_x     = '0;
        host_y     = '0;
        host_pixel = '0;
        fill_start = 1'b0;
        fill_x0    = '0;
        fill_y0    = '0;
        fill_w     = '0;
        fill_h     = '0;
        fill_color = '0;
        tick();
        tick();
        chk("rst we", write_enable, 0);
        chk("rst addr", write_addr, 0);
        chk("rst pix", pixel_in, 0);
        chk("rst err", err_oob, 0);
        chk("rst busy", fill_busy, 0);
        chk("rst done", fill_done, 0);
        chk("rst ready", host_ready, 0);
        reset = 1'b0;
        #1;
        chk("idle ready", host_ready, 1);

        for (int i = 0; i < 6; i++) begin
            host_x     = hv[i].x;
            host_y     = hv[i].y;
            host_pixel = hv[i].pix;
            host_valid = 1'b1;
            #1;
            chk($sformatf("host%0d ready", i), host_ready, 1);
            tick();
            host_valid = 1'b0;
            chk($sformatf("host%0d we", i), write_enable, hv[i].we);
            chk($sformatf("host%0d err", i), err_oob, hv[i].err);
            if (hv[i].we) begin
                chk($sformatf("host%0d addr", i), write_addr, hv[i].addr);
                chk($sformatf("host%0d pix", i), pixel_in, hv[i].pix);
            end
        end
        tick();
        chk("host idle we", write_enable, 0);
        chk("host idle err", err_oob, 0);

        run_fill("fill", 10, 20, 2, 3, 12'hF00, 1'b0, 1'b0);
        run_fill("fillhost", 10, 20, 2, 3, 12'hF00, 1'b1, 1'b0);
        run_fill("clip", 318, 238, 5, 5, 12'h0AA, 1'b0, 1'b0);
        run_fill("w0", 10, 20, 0, 3, 12'h111, 1'b0, 1'b0);
        run_fill("x0oob", 320, 0, 4, 4, 12'h222, 1'b0, 1'b0);
        run_fill("poke", 10, 20, 2, 3, 12'h00F, 1'b0, 1'b1);

        fill_x0    = 9'd10;
        fill_y0    = 8'd20;
        fill_w     = 10'd2;
        fill_h     = 9'd3;
        fill_color = 12'hF00;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        tick();
        chk("midrst pre we", write_enable, 1);
        chk("midrst pre addr", write_addr, 2420);
        reset = 1'b1;
        tick();
        chk("midrst we", write_enable, 0);
        chk("midrst addr", write_addr, 0);
        chk("midrst busy", fill_busy, 0);
        chk("midrst done", fill_done, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("postrst we %0d", i), write_enable, 0);
            chk($sformatf("postrst done %0d", i), fill_done, 0);
        end

`ifdef FB_WRITE_COUNT_EN
        chk("wcnt after rst", write_count, 0);
        host_x     = 9'd7;
        host_y     = 8'd7;
        host_pixel = 12'h777;
        host_valid = 1'b1;
        tick();
        tick();
        tick();
        host_valid = 1'b0;
        tick();
        chk("wcnt", write_count, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
